// File: rtl/vc_buffer_if.sv
// ---------------------------------------------------------------------------
// vc_buffer_if
// Bundle of the push, pop and credit signals of one router input port buffer.
//
// Parameters : DATA_WIDTH (flit width), RAM_DEPTH (entries per VC),
//              NUM_VC (virtual channels). VC_W and CNT_W are derived.
// Signals    : wr_en/wr_vc/data_in        push request
//              rd_en/rd_vc/data_out       pop request and FWFT head flit
//              full/empty/count           per-VC status, count packed
//                                         as VC i in [i*CNT_W +: CNT_W]
//              credit_valid/credit_vc     registered credit to upstream
//              err_ovf/err_udf            sticky error flags, only with
//                                         VC_BUFFER_ERR_EN defined
// Modports   : master (upstream / driver), slave (the buffer)
// ---------------------------------------------------------------------------
interface vc_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 4,
  parameter int NUM_VC     = 2
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(RAM_DEPTH) + 1;

  logic                    wr_en;
  logic [VC_W-1:0]         wr_vc;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    rd_en;
  logic [VC_W-1:0]         rd_vc;
  logic [DATA_WIDTH-1:0]   data_out;
  logic [NUM_VC-1:0]       full;
  logic [NUM_VC-1:0]       empty;
  logic [NUM_VC*CNT_W-1:0] count;
  logic                    credit_valid;
  logic [VC_W-1:0]         credit_vc;
`ifdef VC_BUFFER_ERR_EN
  logic [NUM_VC-1:0]       err_ovf;
  logic [NUM_VC-1:0]       err_udf;

  modport master (
    output wr_en, wr_vc, data_in, rd_en, rd_vc,
    input  data_out, full, empty, count, credit_valid, credit_vc,
           err_ovf, err_udf
  );
  modport slave (
    input  wr_en, wr_vc, data_in, rd_en, rd_vc,
    output data_out, full, empty, count, credit_valid, credit_vc,
           err_ovf, err_udf
  );
`else
  modport master (
    output wr_en, wr_vc, data_in, rd_en, rd_vc,
    input  data_out, full, empty, count, credit_valid, credit_vc
  );
  modport slave (
    input  wr_en, wr_vc, data_in, rd_en, rd_vc,
    output data_out, full, empty, count, credit_valid, credit_vc
  );
`endif
endinterface

// File: rtl/vc_buffer.sv
// ---------------------------------------------------------------------------
// vc_buffer
// Multi-virtual-channel input buffer for one router input port. NUM_VC
// independent FIFOs share one flat storage array (address = vc*RAM_DEPTH +
// ptr). Reads are first-word-fall-through per VC, and every accepted pop
// returns a registered credit one cycle later.
//
// Ports : clk  - single clock, rising edge
//         rst  - asynchronous active-high reset; release is expected to be
//                synchronised to clk outside this block
//         bus  - vc_buffer_if.slave (push, pop, status, credit)
//
// Optional feature: define VC_BUFFER_ERR_EN to add sticky per-VC overflow
// (err_ovf) and underflow (err_udf) flags, cleared only by rst.
// ---------------------------------------------------------------------------
module vc_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 4,
  parameter int NUM_VC     = 2
) (
  input logic       clk,
  input logic       rst,
  vc_buffer_if.slave bus
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(RAM_DEPTH) + 1;
  localparam int PTR_W = $clog2(RAM_DEPTH);

  localparam logic [VC_W:0]    NUM_VC_EXT = (VC_W + 1)'(NUM_VC);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAM_DEPTH);

  // Shared storage. RAM_DEPTH is a power of two, so {vc, ptr} equals
  // vc*RAM_DEPTH + ptr.
  // NOTE: storage has no reset; the counts alone decide which entries are
  // valid, which keeps the array mappable onto plain RAM.
  logic [DATA_WIDTH-1:0] mem [NUM_VC*RAM_DEPTH];

  logic [PTR_W-1:0] wr_ptr [NUM_VC];
  logic [PTR_W-1:0] rd_ptr [NUM_VC];
  logic [CNT_W-1:0] cnt    [NUM_VC];

  logic [NUM_VC-1:0] full_v;
  logic [NUM_VC-1:0] empty_v;

  logic            wr_vc_ok, rd_vc_ok;
  logic [VC_W-1:0] wr_vc_safe, rd_vc_safe;
  logic            push_ok, pop_ok;
  logic [NUM_VC-1:0] push_sel, pop_sel;

  // Status flags come only from registered counts.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through it can infer a latch.
    full_v    = '0;
    empty_v   = '0;
    bus.count = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      full_v[i]                     = (cnt[i] == CNT_FULL);
      empty_v[i]                    = (cnt[i] == '0);
      bus.count[i*CNT_W +: CNT_W]   = cnt[i];
    end
  end

  assign bus.full  = full_v;
  assign bus.empty = empty_v;

  // Out-of-range VC numbers are folded to VC0 for indexing only; the
  // *_ok terms make sure they never cause a state change.
  assign wr_vc_ok   = ({1'b0, bus.wr_vc} < NUM_VC_EXT);
  assign rd_vc_ok   = ({1'b0, bus.rd_vc} < NUM_VC_EXT);
  assign wr_vc_safe = wr_vc_ok ? bus.wr_vc : '0;
  assign rd_vc_safe = rd_vc_ok ? bus.rd_vc : '0;

  // A pop on an empty VC is ignored even with a same-cycle push (no bypass),
  // while a full VC still takes a push when it is popped in the same cycle.
  assign pop_ok  = bus.rd_en && rd_vc_ok && !empty_v[rd_vc_safe];
  assign push_ok = bus.wr_en && wr_vc_ok &&
                   (!full_v[wr_vc_safe] || (pop_ok && (rd_vc_safe == wr_vc_safe)));

  always_comb begin
    push_sel = '0;
    pop_sel  = '0;
    if (push_ok) push_sel[wr_vc_safe] = 1'b1;
    if (pop_ok)  pop_sel[rd_vc_safe]  = 1'b1;
  end

  // FWFT head of the selected VC, zero when there is nothing to show.
  assign bus.data_out = (rd_vc_ok && !empty_v[rd_vc_safe])
                      ? mem[{rd_vc_safe, rd_ptr[rd_vc_safe]}]
                      : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[{wr_vc_safe, wr_ptr[wr_vc_safe]}] <= bus.data_in;
  end

  // Per-VC pointers and occupancy; pointers wrap naturally at RAM_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        // NOTE: non-blocking assignments let every register in this block
        // see the pre-edge values, matching what the hardware does.
        if (push_sel[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_sel[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push_sel[i] && !pop_sel[i])      cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!push_sel[i] && pop_sel[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // One credit per accepted pop, one cycle later. Reset drops a credit that
  // would otherwise have appeared in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.credit_valid <= 1'b0;
      bus.credit_vc    <= '0;
    end else begin
      bus.credit_valid <= pop_ok;
      if (pop_ok) bus.credit_vc <= rd_vc_safe;
    end
  end

`ifdef VC_BUFFER_ERR_EN
  logic [NUM_VC-1:0] wr_req, rd_req;

  always_comb begin
    wr_req = '0;
    rd_req = '0;
    if (bus.wr_en && wr_vc_ok) wr_req[wr_vc_safe] = 1'b1;
    if (bus.rd_en && rd_vc_ok) rd_req[rd_vc_safe] = 1'b1;
  end

  // Sticky: a push into a full VC that is not drained in the same cycle is
  // an overflow; any pop request on an empty VC is an underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err_ovf <= '0;
      bus.err_udf <= '0;
    end else begin
      bus.err_ovf <= bus.err_ovf | (wr_req & full_v & ~pop_sel);
      bus.err_udf <= bus.err_udf | (rd_req & empty_v);
    end
  end
`endif

endmodule

// File: tb/tb_vc_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_buffer
// Self-checking bench for vc_buffer. A queue-per-VC reference model predicts
// data_out, flags, counts and credits; directed scenarios are followed by a
// randomized phase with an asynchronous reset in the middle.
// ---------------------------------------------------------------------------
module tb_vc_buffer;
  localparam int DATA_WIDTH = 8;
  localparam int RAM_DEPTH  = 4;
  localparam int NUM_VC     = 2;
  localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W      = $clog2(RAM_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vc_buffer_if #(.DATA_WIDTH(DATA_WIDTH), .RAM_DEPTH(RAM_DEPTH), .NUM_VC(NUM_VC)) bus ();

  vc_buffer #(.DATA_WIDTH(DATA_WIDTH), .RAM_DEPTH(RAM_DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per VC plus the expected credit.
  logic [DATA_WIDTH-1:0] mq [NUM_VC][$];
  logic                  exp_cv  = 1'b0;
  int                    exp_cvc = 0;
  logic [NUM_VC-1:0]     m_ovf   = '0;
  logic [NUM_VC-1:0]     m_udf   = '0;
  int                    cur_rvc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_VC; i++) mq[i].delete();
    exp_cv = 1'b0;
    m_ovf  = '0;
    m_udf  = '0;
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_VC-1:0]       e_full, e_empty;
    logic [NUM_VC*CNT_W-1:0] e_count;
    logic [DATA_WIDTH-1:0]   e_do;
    e_full  = '0;
    e_empty = '0;
    e_count = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      e_full[i]                 = (mq[i].size() == RAM_DEPTH);
      e_empty[i]                = (mq[i].size() == 0);
      e_count[i*CNT_W +: CNT_W] = CNT_W'(mq[i].size());
    end
    e_do = (mq[cur_rvc].size() != 0) ? mq[cur_rvc][0] : '0;
    check({tag, ".data_out"},     32'(bus.data_out),     32'(e_do));
    check({tag, ".full"},         32'(bus.full),         32'(e_full));
    check({tag, ".empty"},        32'(bus.empty),        32'(e_empty));
    check({tag, ".count"},        32'(bus.count),        32'(e_count));
    check({tag, ".credit_valid"}, 32'(bus.credit_valid), 32'(exp_cv));
    if (exp_cv) check({tag, ".credit_vc"}, 32'(bus.credit_vc), 32'(exp_cvc));
`ifdef VC_BUFFER_ERR_EN
    check({tag, ".err_ovf"}, 32'(bus.err_ovf), 32'(m_ovf));
    check({tag, ".err_udf"}, 32'(bus.err_udf), 32'(m_udf));
`endif
  endtask

  // Called just after a rising edge: drive, check before the next edge,
  // then advance the model across that edge.
  task automatic step(input string tag, input logic wen, input int wvc,
                      input logic [DATA_WIDTH-1:0] din, input logic ren, input int rvc);
    logic pop_acc, push_acc;
    bus.wr_en   = wen;
    bus.wr_vc   = VC_W'(wvc);
    bus.data_in = din;
    bus.rd_en   = ren;
    bus.rd_vc   = VC_W'(rvc);
    cur_rvc     = rvc;
    @(negedge clk);
    check_outputs(tag);
    pop_acc  = ren && (mq[rvc].size() != 0);
    push_acc = wen && ((mq[wvc].size() < RAM_DEPTH) || (pop_acc && rvc == wvc));
    if (wen && mq[wvc].size() == RAM_DEPTH && !(pop_acc && rvc == wvc)) m_ovf[wvc] = 1'b1;
    if (ren && mq[rvc].size() == 0) m_udf[rvc] = 1'b1;
    @(posedge clk);
    #1;
    if (pop_acc)  void'(mq[rvc].pop_front());
    if (push_acc) mq[wvc].push_back(din);
    exp_cv = pop_acc;
    if (pop_acc) exp_cvc = rvc;
  endtask

  // Asserts rst between edges and checks the cleared state before the
  // next rising edge; releases it on a falling edge.
  task automatic do_reset(input string tag);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check_outputs(tag);
    check({tag, ".credit_vc"}, 32'(bus.credit_vc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_vc   = '0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.rd_vc   = '0;
    #1;
    do_reset("reset0");

    // Fill VC0, then an overflowing fifth push.
    step("fill", 1, 0, 8'h11, 0, 0);
    step("fill", 1, 0, 8'h22, 0, 0);
    step("fill", 1, 0, 8'h33, 0, 0);
    step("fill", 1, 0, 8'h44, 0, 0);
    step("ovf",  1, 0, 8'h55, 0, 0);

    // Drain VC0 in order, credits follow each pop.
    for (int k = 0; k < 4; k++) step("drain", 0, 0, 8'h00, 1, 0);
    step("drained", 0, 0, 8'h00, 0, 0);

    // Simultaneous push/pop on a full VC keeps the count at RAM_DEPTH.
    step("refill", 1, 0, 8'h11, 0, 0);
    step("refill", 1, 0, 8'h22, 0, 0);
    step("refill", 1, 0, 8'h33, 0, 0);
    step("refill", 1, 0, 8'h44, 0, 0);
    step("full_pp", 1, 0, 8'hAA, 1, 0);
    for (int k = 0; k < 4; k++) step("pp_drain", 0, 0, 8'h00, 1, 0);

    // Different-VC push and pop in one cycle.
    step("il_fill", 1, 0, 8'h61, 0, 0);
    step("il_fill", 1, 0, 8'h62, 0, 0);
    step("interleave", 1, 1, 8'h5A, 1, 0);
    step("il_peek", 0, 0, 8'h00, 0, 1);

    // Empty both VCs, then push+pop on an empty VC: no bypass, no credit.
    step("il_drain", 0, 0, 8'h00, 1, 1);
    step("il_drain", 0, 0, 8'h00, 1, 0);
    step("empty_pp", 1, 1, 8'h77, 1, 1);
    step("empty_pp_next", 0, 0, 8'h00, 0, 1);
    step("underflow", 0, 0, 8'h00, 1, 0);

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) do_reset("reset_mid");
      step("rand",
           ($urandom_range(0, 9) < 6),
           int'($urandom_range(0, NUM_VC - 1)),
           DATA_WIDTH'($urandom),
           ($urandom_range(0, 9) < 5),
           int'($urandom_range(0, NUM_VC - 1)));
    end
    step("final", 0, 0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
